// File: rtl/ub_pkg.sv
// Shared types and default sizing for the unified-buffer read path.
// Consumed by unified_buffer_reader and ub_skew_mux.
package ub_pkg;

  localparam int UB_DATA_W = 32;
  localparam int UB_ADDR_W = 6;
  localparam int UB_N      = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN,
    DONE
  } ub_rd_state_t;

  typedef logic [UB_DATA_W-1:0] ub_word_t;

endpackage

// File: rtl/ub_skew_mux.sv
// Per-lane selection of the staged matrix element for drain step t (lane r lags r steps).
// UB_READER_TRANSPOSE_EN selects M[t-r][r] instead of M[r][t-r].
module ub_skew_mux
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int N      = UB_N,
  parameter int T_W    = $clog2(2 * UB_N)
) (
  input  logic [T_W-1:0]    step_i,
  input  logic [DATA_W-1:0] stg_i  [N*N],
  output logic [DATA_W-1:0] word_o [N],
  output logic [N-1:0]      vld_o
);

  int col;
  int sel;

  always_comb begin
    vld_o = '0;
    col   = 0;
    sel   = 0;
    for (int r = 0; r < N; r++) begin
      word_o[r] = '0;
      col = int'(step_i) - r;
      if (col >= 0 && col < N) begin
        vld_o[r] = 1'b1;
`ifdef UB_READER_TRANSPOSE_EN
        sel = col * N + r;
`else
        sel = r * N + col;
`endif
        for (int e = 0; e < N * N; e++) begin
          if (e == sel) word_o[r] = stg_i[e];
        end
      end
    end
  end

endmodule

// File: rtl/unified_buffer_reader.sv
// Fetches an N x N matrix from unified memory and replays it diagonally skewed onto the array rows.
// Optional UB_READER_TRANSPOSE_EN streams the transpose (handled inside ub_skew_mux).
module unified_buffer_reader
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int ADDR_W = UB_ADDR_W,
  parameter int N      = UB_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [N*DATA_W-1:0]   lane_data,
  output logic [N-1:0]          lane_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int NN    = N * N;
  localparam int CNT_W = $clog2(NN + 1);
  localparam int T_W   = $clog2(2 * N);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NN - 1);
  localparam logic [T_W-1:0]   T_LAST = T_W'(2 * N - 2);

  ub_rd_state_t          state_q;
  logic [CNT_W-1:0]      k_q;
  logic [T_W-1:0]        t_q;
  logic                  rd_en_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [N*DATA_W-1:0]   lane_data_q;
  logic [N-1:0]          lane_valid_q;

  logic                  rd_vld_q;
  logic [CNT_W-1:0]      cap_q, cap_d;
  logic [DATA_W-1:0]     stg_q [NN];
  logic [DATA_W-1:0]     stg_d [NN];

  logic [T_W-1:0]        step_sel;
  logic [DATA_W-1:0]     mux_word [N];
  logic [N-1:0]          mux_vld;
  logic [N*DATA_W-1:0]   lane_data_d;

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign lane_data  = lane_data_q;
  assign lane_valid = lane_valid_q;

  // Capture stage: memory returns one cycle after each request
  always_comb begin
    stg_d = stg_q;
    cap_d = cap_q;
    if (rd_vld_q) begin
      for (int e = 0; e < NN; e++) begin
        if (CNT_W'(e) == cap_q) stg_d[e] = rd_data;
      end
      cap_d = cap_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      cap_q    <= '0;
      for (int e = 0; e < NN; e++) stg_q[e] <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      cap_q    <= (state_q == IDLE && start) ? '0 : cap_d;
      stg_q    <= stg_d;
    end
  end

  // Skew stage: the mux sees the next-cycle staging view so a word landing this edge is usable
  assign step_sel = (state_q == DRAIN) ? t_q + T_W'(1) : '0;

  ub_skew_mux #(
    .DATA_W (DATA_W),
    .N      (N),
    .T_W    (T_W)
  ) u_skew_mux (
    .step_i (step_sel),
    .stg_i  (stg_d),
    .word_o (mux_word),
    .vld_o  (mux_vld)
  );

  always_comb begin
    lane_data_d = '0;
    for (int r = 0; r < N; r++) lane_data_d[r*DATA_W +: DATA_W] = mux_word[r];
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      t_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_addr;
            k_q       <= '0;
            busy_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (k_q == K_LAST) begin
            state_q   <= WAIT;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            k_q       <= k_q + CNT_W'(1);
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        WAIT: begin
          state_q      <= DRAIN;
          t_q          <= '0;
          lane_data_q  <= lane_data_d;
          lane_valid_q <= mux_vld;
        end
        DRAIN: begin
          if (!stall) begin
            if (t_q == T_LAST) begin
              state_q      <= DONE;
              lane_data_q  <= '0;
              lane_valid_q <= '0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              t_q          <= t_q + T_W'(1);
              lane_data_q  <= lane_data_d;
              lane_valid_q <= mux_vld;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_buffer_reader.sv
// Directed + randomized bench for unified_buffer_reader against a timeline model of the read/drain sequence.
// Honours UB_READER_TRANSPOSE_EN in its expected lane contents.
module tb_unified_buffer_reader;
  import ub_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 2;
  localparam int NN = N * N;

  logic              clk;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              stall;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic [N*DW-1:0]   lane_data;
  logic [N-1:0]      lane_valid;
  logic              busy;
  logic              done;

  ub_word_t mem [64];
  int n_chk;
  int n_fail;

  unified_buffer_reader #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N      (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .stall      (stall),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the request, garbage otherwise
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input logic e_en, input bit chk_addr, input int e_addr,
                           input logic e_busy, input logic e_done,
                           input logic [N-1:0] e_v, input logic [N*DW-1:0] e_d);
    chk("rd_en", 64'(rd_en), 64'(e_en));
    if (chk_addr) chk("rd_addr", 64'(rd_addr), 64'(e_addr));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("lane_valid", 64'(lane_valid), 64'(e_v));
    chk("lane_data", 64'(lane_data), 64'(e_d));
  endtask

  // Matrix element [i][j] lives at base + i*N + j (mod 64)
  function automatic ub_word_t elem(input int base, input int i, input int j);
    logic [AW-1:0] a;
    a = AW'(base + i * N + j);
    return mem[a];
  endfunction

  function automatic void exp_lanes(input int base, input int t,
                                    output logic [N-1:0] v, output logic [N*DW-1:0] dat);
    int col;
    v   = '0;
    dat = '0;
    for (int r = 0; r < N; r++) begin
      col = t - r;
      if (col >= 0 && col < N) begin
        v[r] = 1'b1;
`ifdef UB_READER_TRANSPOSE_EN
        dat[r*DW +: DW] = elem(base, col, r);
`else
        dat[r*DW +: DW] = elem(base, r, col);
`endif
      end
    end
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[AW'(i)] = $urandom;
  endtask

  // One operation launched from an idle cycle; s/L = stall step and length (s<0: none)
  task automatic run_op(input int base, input int s, input int L, input bit glitch,
                        input int abort_at, output bit aborted);
    int last;
    int d;
    int t;
    logic [N-1:0]    v;
    logic [N*DW-1:0] dat;
    last    = NN + 1 + (2 * N - 1 + L) + 1;
    aborted = 1'b0;
    start     = 1'b1;
    base_addr = AW'(base);
    for (int c = 1; c <= last; c++) begin
      tick();
      start     = glitch ? 1'($urandom) : 1'b0;
      base_addr = AW'($urandom);
      stall     = 1'($urandom);
      if (c <= NN) begin
        chk_cycle(1'b1, 1'b1, (base + c - 1) % 64, 1'b1, 1'b0, '0, '0);
      end else if (c == NN + 1) begin
        chk_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, '0, '0);
      end else if (c < last) begin
        d = c - (NN + 2);
        if (d <= s)          t = d;
        else if (d <= s + L) t = s;
        else                 t = d - L;
        stall = (d >= s && d < s + L);
        exp_lanes(base, t, v, dat);
        chk_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, v, dat);
      end else begin
        chk_cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, '0, '0);
      end
      if (c == abort_at) begin
        reset   = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_check();
    tick();
    start = 1'b0;
    stall = 1'($urandom);
    chk_cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic post_abort();
    tick();
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    chk_cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) idle_check();
  endtask

  initial begin
    bit ab;
    int b;
    int s;
    int L;
    n_chk  = 0;
    n_fail = 0;
    fill_mem();

    // Reset together with start: reset must win
    reset     = 1'b1;
    start     = 1'b1;
    stall     = 1'b1;
    base_addr = AW'(4);
    tick();
    tick();
    chk_cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    idle_check();
    idle_check();

    // Directed matrix 10..13 at 4..7
    for (int i = 0; i < NN; i++) mem[AW'(4 + i)] = DW'(10 + i);
    run_op(4, -1, 0, 1'b0, 0, ab);
    idle_check();

    // Address wrap 62,63,0,1
    mem[AW'(62)] = DW'(20); mem[AW'(63)] = DW'(21);
    mem[AW'(0)]  = DW'(22); mem[AW'(1)]  = DW'(23);
    run_op(62, -1, 0, 1'b0, 0, ab);
    idle_check();

    // Stall two cycles at drain step 1
    run_op(4, 1, 2, 1'b0, 0, ab);
    idle_check();

    // Start pulses while busy are ignored
    run_op(4, -1, 0, 1'b1, 0, ab);
    idle_check();
    idle_check();

    // Reset in drain cycle 7, then a normal run
    run_op(4, -1, 0, 1'b0, 7, ab);
    post_abort();
    run_op(4, -1, 0, 1'b0, 0, ab);
    idle_check();

    // Reset during fetch
    run_op(int'($urandom_range(63, 0)), -1, 0, 1'b0, int'($urandom_range(NN, 1)), ab);
    post_abort();

    // Randomized back-to-back operations
    for (int i = 0; i < 20; i++) begin
      fill_mem();
      b = int'($urandom_range(63, 0));
      L = int'($urandom_range(3, 0));
      s = (L == 0) ? -1 : int'($urandom_range(2 * N - 2, 0));
      run_op(b, s, L, 1'($urandom), 0, ab);
      idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
